fetch_unit: RTL and testbench

Parametrised successor to the single-cycle fetch stage: holds the program counter, selects the next PC from sequential, relative-branch, absolute-jump, call and return sources, and keeps a bounded return-address stack. It also counts retired instructions and raises Done on a halt. It sits between the control/ALU outputs (branch decision, targets) and the instruction ROM address input in the top level.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 34 +++
 rtl/ret_stack.sv | 38 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the fetch stage
package fetch_pkg;
  localparam int DEF_PC_W      = 8;
  localparam int DEF_OFF_W     = 6;
  localparam int DEF_RAS_DEPTH = 4;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    REL  = 2'd1,
    ABS  = 2'd2,
    RSVD = 2'd3
  } br_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control inputs and status outputs of the fetch stage
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             Start;
  logic [PC_W-1:0]  Start_Addr;
  logic             Stall;
  logic             BrTaken;
  br_mode_t         BrMode;
  logic [OFF_W-1:0] Offset;
  logic [PC_W-1:0]  Target;
  logic             Call;
  logic             Ret;
  logic             Halt;
  logic [PC_W-1:0]  PC;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;
  logic             RasOverflow;
  logic             RasUnderflow;

  modport master (
    output Start, Start_Addr, Stall, BrTaken, BrMode, Offset, Target, Call, Ret, Halt,
    input  PC, Done, InstrCount, RasOverflow, RasUnderflow
  );

  modport slave (
    input  Start, Start_Addr, Stall, BrTaken, BrMode, Offset, Target, Call, Ret, Halt,
    output PC, Done, InstrCount, RasOverflow, RasUnderflow
  );
endinterface

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - bounded return-address stack; pop has priority over push
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         Push,
  input  logic         Pop,
  input  logic [W-1:0] PushData,
  output logic         Full,
  output logic         Empty,
  output logic [W-1:0] Top
);
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] topIdx;

  assign Full   = (ptr == PTR_W'(DEPTH));
  assign Empty  = (ptr == '0);
  assign topIdx = ptr - PTR_W'(1);
  assign Top    = Empty ? '0 : mem[topIdx[IDX_W-1:0]];

  always_ff @(posedge CLK) begin
    if (Reset || Clear) begin
      ptr <= '0;
    end else if (Pop && !Empty) begin
      ptr <= topIdx;
    end else if (Push && !Full) begin
      mem[ptr[IDX_W-1:0]] <= PushData;
      ptr                 <= ptr + PTR_W'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, next-PC select, return stack and retire counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic         CLK,
  input logic         Reset,
  fetch_unit_if.slave bus
);
  state_t           state, stateNext;
  logic [PC_W-1:0]  pcQ, pcNext, pcInc, relOff, rasTop;
  logic [CNT_W-1:0] cntQ, cntNext;
  logic             doneQ, doneNext;
  logic             ovfQ, ovfNext;
  logic             unfQ, unfNext;
  logic             rasPush, rasPop, rasClear, rasFull, rasEmpty;
  logic             advance;

  assign pcInc   = pcQ + PC_W'(1);
  assign relOff  = PC_W'($signed(bus.Offset));
  assign advance = (state == RUN) && !bus.Stall && !bus.Start;

  ret_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ret_stack (
    .CLK     (CLK),
    .Reset   (Reset),
    .Clear   (rasClear),
    .Push    (rasPush),
    .Pop     (rasPop),
    .PushData(pcInc),
    .Full    (rasFull),
    .Empty   (rasEmpty),
    .Top     (rasTop)
  );

  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    cntNext   = cntQ;
    doneNext  = doneQ;
    ovfNext   = ovfQ;
    unfNext   = unfQ;
    rasPush   = 1'b0;
    rasPop    = 1'b0;
    rasClear  = 1'b0;

    if (bus.Start) begin
      stateNext = RUN;
      pcNext    = bus.Start_Addr;
      cntNext   = '0;
      doneNext  = 1'b0;
      ovfNext   = 1'b0;
      unfNext   = 1'b0;
      rasClear  = 1'b1;
    end else if (advance) begin
      if (cntQ != '1) cntNext = cntQ + CNT_W'(1);
      if (bus.Halt) begin
        stateNext = DONE;
        doneNext  = 1'b1;
      end else if (bus.Ret) begin
        // An empty-stack return falls through to the next instruction.
        if (rasEmpty) begin
          unfNext = 1'b1;
          pcNext  = pcInc;
        end else begin
          rasPop = 1'b1;
          pcNext = rasTop;
        end
      end else if (bus.Call) begin
        if (rasFull) ovfNext = 1'b1;
        else         rasPush = 1'b1;
        pcNext = bus.Target;
      end else if (bus.BrTaken && bus.BrMode == REL) begin
        pcNext = pcQ + relOff;
      end else if (bus.BrTaken && bus.BrMode == ABS) begin
        pcNext = bus.Target;
      end else begin
        pcNext = pcInc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      pcQ   <= '0;
      cntQ  <= '0;
      doneQ <= 1'b0;
      ovfQ  <= 1'b0;
      unfQ  <= 1'b0;
    end else begin
      state <= stateNext;
      pcQ   <= pcNext;
      cntQ  <= cntNext;
      doneQ <= doneNext;
      ovfQ  <= ovfNext;
      unfQ  <= unfNext;
    end
  end

  assign bus.PC           = pcQ;
  assign bus.Done         = doneQ;
  assign bus.InstrCount   = cntQ;
  assign bus.RasOverflow  = ovfQ;
  assign bus.RasUnderflow = unfQ;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue-based model
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W    = DEF_PC_W;
  localparam int OFF_W   = DEF_OFF_W;
  localparam int DEPTH   = DEF_RAS_DEPTH;
  localparam int CNT_W   = DEF_CNT_W;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int OFF_MOD = 1 << OFF_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic Reset;
  fetch_unit_if bus ();

  fetch_unit dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int errCount   = 0;
  int checkCount = 0;

  // Model: 0 idle, 1 run, 2 done; stack is a plain queue, back = top.
  int mState;
  int mPc;
  int mCnt;
  int mDone;
  int mOvf;
  int mUnf;
  int mStack[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    Reset          = 1'b0;
    bus.Start      = 1'b0;
    bus.Start_Addr = '0;
    bus.Stall      = 1'b0;
    bus.BrTaken    = 1'b0;
    bus.BrMode     = SEQ;
    bus.Offset     = '0;
    bus.Target     = '0;
    bus.Call       = 1'b0;
    bus.Ret        = 1'b0;
    bus.Halt       = 1'b0;
  endtask

  task automatic modelStep();
    int off;
    if (Reset) begin
      mState = 0; mPc = 0; mCnt = 0; mDone = 0; mOvf = 0; mUnf = 0;
      mStack.delete();
    end else if (bus.Start) begin
      mState = 1; mPc = int'(bus.Start_Addr); mCnt = 0; mDone = 0; mOvf = 0; mUnf = 0;
      mStack.delete();
    end else if (mState == 1 && !bus.Stall) begin
      if (mCnt < CNT_MAX) mCnt++;
      if (bus.Halt) begin
        mState = 2;
        mDone  = 1;
      end else if (bus.Ret) begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin
          mUnf = 1;
          mPc  = (mPc + 1) % PC_MOD;
        end
      end else if (bus.Call) begin
        if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % PC_MOD);
        else mOvf = 1;
        mPc = int'(bus.Target);
      end else if (bus.BrTaken && bus.BrMode == REL) begin
        off = int'(bus.Offset);
        if (off >= OFF_MOD / 2) off -= OFF_MOD;
        mPc = (mPc + off + PC_MOD) % PC_MOD;
      end else if (bus.BrTaken && bus.BrMode == ABS) begin
        mPc = int'(bus.Target);
      end else begin
        mPc = (mPc + 1) % PC_MOD;
      end
    end
  endtask

  task automatic stepQuiet();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    stepQuiet();
    checkVal("pc", bus.PC, mPc);
    checkVal("done", bus.Done, mDone);
    checkVal("count", bus.InstrCount, mCnt);
    checkVal("ovf", bus.RasOverflow, mOvf);
    checkVal("unf", bus.RasUnderflow, mUnf);
  endtask

  task automatic startAt(input logic [PC_W-1:0] addr);
    clearIn();
    bus.Start      = 1'b1;
    bus.Start_Addr = addr;
    step();
    clearIn();
  endtask

  initial begin
    logic [PC_W-1:0] retExp [5];
    retExp = '{8'h31, 8'h21, 8'h11, 8'h01, 8'h02};

    clearIn();
    Reset = 1'b1;
    step();
    checkVal("rst_pc", bus.PC, 0);
    checkVal("rst_done", bus.Done, 0);
    checkVal("rst_cnt", bus.InstrCount, 0);
    checkVal("rst_flags", {bus.RasOverflow, bus.RasUnderflow}, 0);

    startAt(8'h10);
    checkVal("start_pc", bus.PC, 8'h10);
    for (int i = 1; i <= 3; i++) begin
      step();
      checkVal("seq_pc", bus.PC, 8'h10 + i);
    end
    checkVal("seq_cnt", bus.InstrCount, 3);

    startAt(8'hFF);
    step();
    checkVal("wrap_pc", bus.PC, 8'h00);

    startAt(8'h20);
    bus.BrMode = REL; bus.Offset = 6'h3C; bus.BrTaken = 1'b1;
    step();
    checkVal("rel_taken", bus.PC, 8'h1C);
    startAt(8'h20);
    bus.BrMode = REL; bus.Offset = 6'h3C; bus.BrTaken = 1'b0;
    step();
    checkVal("rel_not_taken", bus.PC, 8'h21);
    bus.BrMode = ABS; bus.Target = 8'h80; bus.BrTaken = 1'b1;
    step();
    checkVal("abs_pc", bus.PC, 8'h80);

    startAt(8'h05);
    bus.Call = 1'b1; bus.Target = 8'h40;
    step();
    checkVal("call_pc", bus.PC, 8'h40);
    clearIn();
    repeat (7) step();
    checkVal("pre_ret_pc", bus.PC, 8'h47);
    bus.Ret = 1'b1;
    step();
    checkVal("ret_pc", bus.PC, 8'h06);

    startAt(8'h00);
    for (int i = 0; i < 5; i++) begin
      clearIn();
      bus.Call = 1'b1; bus.Target = PC_W'((i + 1) * 16);
      step();
      checkVal("nest_call_pc", bus.PC, (i + 1) * 16);
      checkVal("nest_ovf", bus.RasOverflow, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      clearIn();
      bus.Ret = 1'b1;
      step();
      checkVal("nest_ret_pc", bus.PC, retExp[i]);
      checkVal("nest_unf", bus.RasUnderflow, (i == 4) ? 1 : 0);
    end

    startAt(8'h60);
    bus.Call = 1'b1; bus.Target = 8'h70; bus.Stall = 1'b1;
    repeat (3) step();
    checkVal("stall_pc", bus.PC, 8'h60);
    checkVal("stall_cnt", bus.InstrCount, 0);
    bus.Stall = 1'b0;
    step();
    checkVal("unstall_call", bus.PC, 8'h70);
    bus.Call = 1'b1; bus.Ret = 1'b1; bus.Target = 8'h99;
    step();
    checkVal("call_ret_pop", bus.PC, 8'h61);
    clearIn();
    bus.Ret = 1'b1;
    step();
    checkVal("call_ret_nopush", bus.RasUnderflow, 1);
    checkVal("call_ret_nopush_pc", bus.PC, 8'h62);

    startAt(8'h29);
    repeat (2) step();
    bus.Ret = 1'b1;
    step();
    clearIn();
    repeat (4) step();
    checkVal("pre_halt_pc", bus.PC, 8'h30);
    bus.Halt = 1'b1;
    step();
    checkVal("halt_done", bus.Done, 1);
    checkVal("halt_cnt", bus.InstrCount, 8);
    for (int i = 0; i < 5; i++) begin
      clearIn();
      bus.Call    = 1'($urandom);
      bus.Ret     = 1'($urandom);
      bus.BrTaken = 1'b1;
      bus.BrMode  = ABS;
      bus.Target  = PC_W'($urandom);
      step();
      checkVal("halt_hold_pc", bus.PC, 8'h30);
    end
    startAt(8'h00);
    checkVal("restart_done", bus.Done, 0);
    checkVal("restart_cnt", bus.InstrCount, 0);
    checkVal("restart_unf", bus.RasUnderflow, 0);

    startAt(8'h50);
    bus.Call = 1'b1; bus.Target = 8'h60;
    step();
    bus.Target = 8'h70;
    step();
    clearIn();
    Reset = 1'b1; bus.Call = 1'b1;
    step();
    checkVal("midrst_pc", bus.PC, 0);
    checkVal("midrst_cnt", bus.InstrCount, 0);
    clearIn();
    step();
    checkVal("midrst_idle", bus.PC, 0);
    Reset = 1'b1; bus.Start = 1'b1; bus.Start_Addr = 8'h33;
    step();
    checkVal("rst_start_pc", bus.PC, 0);
    clearIn();
    step();
    checkVal("rst_start_idle", bus.PC, 0);
    startAt(8'h10);
    bus.Ret = 1'b1;
    step();
    checkVal("midrst_empty_unf", bus.RasUnderflow, 1);
    checkVal("midrst_empty_pc", bus.PC, 8'h11);

    for (int i = 0; i < 600; i++) begin
      clearIn();
      Reset          = ($urandom_range(59) == 0);
      bus.Start      = ($urandom_range(19) == 0);
      bus.Start_Addr = PC_W'($urandom);
      bus.Stall      = ($urandom_range(4) == 0);
      bus.Halt       = ($urandom_range(29) == 0);
      bus.Call       = ($urandom_range(4) == 0);
      bus.Ret        = ($urandom_range(4) == 0);
      bus.BrTaken    = 1'($urandom);
      bus.BrMode     = br_mode_t'($urandom_range(3));
      bus.Offset     = OFF_W'($urandom);
      bus.Target     = PC_W'($urandom);
      step();
    end

    startAt(8'h00);
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      if (i % 8192 == 0) step();
      else stepQuiet();
    end
    step();
    checkVal("cnt_sat", bus.InstrCount, CNT_MAX);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
